// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for the DIV/DIVU/REM/REMU operations of
//   the EX stage. It produces one quotient bit per cycle. The latency is fixed
//   for every operand pair, including divide-by-zero and signed overflow.
//
// Ports
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous active-high reset
//   start      in   1           request; honoured only in IDLE or DONE
//   operation  in   5           alu_operation_t code; only the four divide ops accepted
//   dividend   in   DATA_WIDTH  rs1 value, sampled with start
//   divisor    in   DATA_WIDTH  rs2 value, sampled with start
//   flush      in   1           synchronous abort; wins over start
//   busy       out  1           high while iterating (EX stage stalls)
//   done       out  1           one-cycle pulse, result valid
//   result     out  DATA_WIDTH  quotient or remainder; held until the next completion
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int         DATA_WIDTH = 32,
  parameter int         CNT_WIDTH  = $clog2(DATA_WIDTH) + 1,
  parameter logic [4:0] OP_DIV     = 5'd12,
  parameter logic [4:0] OP_DIVU    = 5'd13,
  parameter logic [4:0] OP_REM     = 5'd14,
  parameter logic [4:0] OP_REMU    = 5'd15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            operation,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0]  INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]  ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0]   LAST_IT  = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Two's-complement magnitude of a signed operand. INT_MIN maps onto itself,
  // which is the correct unsigned magnitude 2^(W-1).
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v);
    magnitude = v[DATA_WIDTH-1] ? DATA_WIDTH'(-v) : DATA_WIDTH'(v);
  endfunction

  // Restores the sign of an unsigned quotient or remainder magnitude.
  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                              input logic neg);
    logic signed [DATA_WIDTH-1:0] s;
    s = $signed(mag);
    apply_sign = neg ? -s : s;
  endfunction

  state_t                 state;
  logic [DATA_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0]  quo_q;
  logic [DATA_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0]  dvd_raw;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   is_rem;
  logic                   neg_q;
  logic                   neg_r;
  logic                   div_zero;
  logic                   ovf;

  // Request decode
  logic                         op_valid;
  logic                         op_signed;
  logic                         op_rem;
  logic signed [DATA_WIDTH-1:0] dvd_s;
  logic signed [DATA_WIDTH-1:0] dvs_s;
  logic                         dvd_neg;
  logic                         dvs_neg;

  assign op_valid  = (operation == OP_DIV) || (operation == OP_DIVU) ||
                     (operation == OP_REM) || (operation == OP_REMU);
  assign op_signed = (operation == OP_DIV) || (operation == OP_REM);
  assign op_rem    = (operation == OP_REM) || (operation == OP_REMU);
  assign dvd_s     = $signed(dividend);
  assign dvs_s     = $signed(divisor);
  assign dvd_neg   = op_signed & dividend[DATA_WIDTH-1];
  assign dvs_neg   = op_signed & divisor[DATA_WIDTH-1];

  // One restoring step. The shifted remainder needs W+1 bits because it can
  // reach 2*divisor-1 before the subtraction.
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   rem_diff;
  logic                  rem_ge;
  logic [DATA_WIDTH-1:0] rem_nxt;
  logic [DATA_WIDTH-1:0] quo_nxt;

  assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, div_q};
  assign rem_ge   = (rem_sh >= {1'b0, div_q});
  assign rem_nxt  = rem_ge ? rem_diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
  assign quo_nxt  = {quo_q[DATA_WIDTH-2:0], rem_ge};

  // Final value taken on the CALC->DONE edge from the last step's output.
  logic [DATA_WIDTH-1:0] final_res;

  always_comb begin
    final_res = '0;
    if (div_zero)
      final_res = is_rem ? dvd_raw : ALL_ONES;
    else if (ovf)
      final_res = is_rem ? '0 : INT_MIN;
    else if (is_rem)
      final_res = apply_sign(rem_nxt, neg_r);
    else
      final_res = apply_sign(quo_nxt, neg_q);
  end

  // Control FSM and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      dvd_raw  <= '0;
      cnt      <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start && op_valid) begin
            state    <= CALC;
            busy     <= 1'b1;
            rem_q    <= '0;
            quo_q    <= op_signed ? magnitude(dvd_s) : dividend;
            div_q    <= op_signed ? magnitude(dvs_s) : divisor;
            dvd_raw  <= dividend;
            cnt      <= '0;
            is_rem   <= op_rem;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            div_zero <= (divisor == '0);
            ovf      <= op_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_IT) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= final_res;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboard bench for div_unit. Stimulus pushes expected results (value and
//   completion cycle) into a queue. A monitor sampling 1 ns after each rising
//   edge pops and compares on done. It also tracks the expected busy window
//   and checks that result is held between completions.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int         W       = 32;
  localparam logic [4:0] OP_DIV  = 5'd12;
  localparam logic [4:0] OP_DIVU = 5'd13;
  localparam logic [4:0] OP_REM  = 5'd14;
  localparam logic [4:0] OP_REMU = 5'd15;
  localparam int         LAT     = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   operation = '0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           busy_lo = 1;
  int           busy_hi = 0;
  logic [W-1:0] last_res = '0;
  int           vectors = 0;
  int           miscompares = 0;

  // Reference model from the ISA definition of the four divide operations.
  function automatic logic [W-1:0] ref_model(input logic [4:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int  sa;
    int  sb;
    bit  ovfl;
    sa   = a;
    sb   = b;
    ovfl = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: ref_model = (b == 0) ? a : a % b;
      OP_DIV:  ref_model = (b == 0) ? 32'hFFFF_FFFF : (ovfl ? a : 32'(sa / sb));
      OP_REM:  ref_model = (b == 0) ? a : (ovfl ? 32'h0 : 32'(sa % sb));
      default: ref_model = '0;
    endcase
  endfunction

  function automatic bit is_div_op(input logic [4:0] op);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
    end
  endtask

  // Monitor: one sample per cycle, 1 ns after the rising edge.
  always begin
    @(posedge clk);
    #1;
    check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
    check("busy_done_excl", {31'b0, busy & done}, 32'h0);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("done_pulse", {31'b0, done}, 32'h1);
      check("result", result, exp_q[0].res);
      last_res = exp_q[0].res;
      void'(exp_q.pop_front());
    end else begin
      check("no_done", {31'b0, done}, 32'h0);
      check("result_held", result, last_res);
    end
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL overdue at cycle %0d: got no done, expected done at cycle %0d", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  // Drives a request in the current cycle (call right after a falling edge).
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    operation = op;
    dividend  = a;
    divisor   = b;
    if (is_div_op(op)) begin
      exp_q.push_back('{res: ref_model(op, a, b), due: cyc + LAT});
      busy_lo = cyc + 1;
      busy_hi = cyc + LAT - 1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t0;
    @(negedge clk);
    t0 = cyc;
    issue(op, a, b);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed values
    run_op(OP_DIV,  32'd20, 32'd3);
    run_op(OP_REM,  32'hFFFF_FFEC, 32'd3);
    run_op(OP_DIV,  32'hFFFF_FFEC, 32'd3);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    run_op(OP_DIVU, 32'd7, 32'd0);
    run_op(OP_REMU, 32'd7, 32'd0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV,  32'hFFFF_FFEC, 32'd0);
    run_op(OP_REM,  32'hFFFF_FFEC, 32'd0);
    run_op(OP_REM,  32'd20, 32'hFFFF_FFFD);

    // Non-divide op is ignored
    @(negedge clk);
    issue(5'd0, 32'd50, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // start held through CALC gives a single completion
    @(negedge clk);
    t0 = cyc;
    issue(OP_DIVU, 32'd1000, 32'd9);
    wait_until(t0 + 20);
    start = 1'b0;
    wait_until(t0 + LAT + 3);

    // Back-to-back request accepted in the DONE cycle
    @(negedge clk);
    t0 = cyc;
    issue(OP_DIV, 32'd77, 32'd7);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT);
    issue(OP_REM, 32'd77, 32'd10);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 2 * LAT + 1);

    // Flush in CALC: no completion, result unchanged
    @(negedge clk);
    t0 = cyc;
    issue(OP_DIVU, 32'd123456, 32'd11);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 10);
    flush   = 1'b1;
    busy_hi = t0 + 10;
    void'(exp_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    wait_until(t0 + LAT + 5);

    // Flush beats start in the DONE cycle
    @(negedge clk);
    t0 = cyc;
    issue(OP_DIVU, 32'd90, 32'd4);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + LAT);
    start     = 1'b1;
    flush     = 1'b1;
    operation = OP_DIV;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    wait_until(t0 + 2 * LAT + 2);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    t0 = cyc;
    issue(OP_DIV, 32'd5000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 15);
    rst = 1'b1;
    exp_q.delete();
    busy_lo  = 1;
    busy_hi  = 0;
    last_res = '0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_DIV, 32'd100, 32'd7);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op = 5'(12 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       b = a >> $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(op, a, b);
    end

    repeat (3) @(negedge clk);
    check("pending", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
